// File: rtl/dsram_pkg.sv
// rtl/dsram_pkg.sv - shared constants and byte-lane helper for the data-SRAM responder
package dsram_pkg;

    localparam logic [15:0] CONF_HI_DEFAULT = 16'hbfaf;

    localparam logic [15:0] OFF_LED     = 16'hf000;
    localparam logic [15:0] OFF_SWITCH  = 16'hf010;
    localparam logic [15:0] OFF_TIMER   = 16'he000;
    localparam logic [15:0] OFF_SCRATCH = 16'hf020;

    function automatic logic [31:0] byte_merge(input logic [31:0] old_w,
                                               input logic [31:0] new_w,
                                               input logic [3:0]  wen);
        logic [31:0] res;
        for (int i = 0; i < 4; i++) begin
            res[8*i +: 8] = wen[i] ? new_w[8*i +: 8] : old_w[8*i +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/data_sram_resp_if.sv
// rtl/data_sram_resp_if.sv - CPU data-SRAM request/response bundle
interface data_sram_resp_if;
    logic        en;
    logic [3:0]  wen;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;

    modport master (output en, output wen, output addr, output wdata, input rdata);
    modport slave  (input en, input wen, input addr, input wdata, output rdata);
endinterface

// File: rtl/conf_regs.sv
// rtl/conf_regs.sv - LED/switch/timer/scratch register window with combinational read mux
module conf_regs
    import dsram_pkg::*;
(
    input  logic        clk,
    input  logic        resetn,
    input  logic        wr_en,
    input  logic [3:0]  wen,
    input  logic [15:0] offset,
    input  logic [31:0] wdata,
    input  logic [7:0]  switch,
    output logic [15:0] led,
    output logic [31:0] rdata
);

    logic [31:0] timer;
    logic [31:0] scratch;
    logic [7:0]  sw_meta;
    logic [7:0]  sw_sync;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            led     <= 16'h0;
            timer   <= 32'h0;
            scratch <= 32'h0;
            sw_meta <= 8'h0;
            sw_sync <= 8'h0;
        end else begin
            sw_meta <= switch;
            sw_sync <= sw_meta;
            // A timer write wins over the free-running increment
            if (wr_en && offset == OFF_TIMER) begin
                timer <= byte_merge(timer, wdata, wen);
            end else begin
                timer <= timer + 32'd1;
            end
            if (wr_en && offset == OFF_LED) begin
                led <= {wen[1] ? wdata[15:8] : led[15:8],
                        wen[0] ? wdata[7:0]  : led[7:0]};
            end
            if (wr_en && offset == OFF_SCRATCH) begin
                scratch <= byte_merge(scratch, wdata, wen);
            end
        end
    end

    always_comb begin
        rdata = 32'h0;
        case (offset)
            OFF_LED:     rdata = {16'h0, led};
            OFF_SWITCH:  rdata = {24'h0, sw_sync};
            OFF_TIMER:   rdata = timer;
            OFF_SCRATCH: rdata = scratch;
            default:     rdata = 32'h0;
        endcase
    end

endmodule

// File: rtl/data_sram_resp.sv
// rtl/data_sram_resp.sv - data-SRAM responder: word RAM plus config window, one-cycle read latency
module data_sram_resp
    import dsram_pkg::*;
#(
    parameter int          ADDR_W  = 12,
    parameter logic [15:0] CONF_HI = CONF_HI_DEFAULT
) (
    input  logic             clk,
    input  logic             resetn,
    data_sram_resp_if.slave  data_sram,
    output logic [15:0]      led,
    input  logic [7:0]       switch
);

    logic [31:0]       mem [0:(1 << ADDR_W) - 1];
    logic              conf_sel;
    logic [ADDR_W-1:0] word_idx;
    logic [31:0]       conf_rdata;
    logic              conf_wr;

    assign conf_sel = (data_sram.addr[31:16] == CONF_HI);
    assign word_idx = data_sram.addr[ADDR_W+1:2];
    assign conf_wr  = data_sram.en && conf_sel && (data_sram.wen != 4'h0);

    conf_regs u_conf_regs (
        .clk    (clk),
        .resetn (resetn),
        .wr_en  (conf_wr),
        .wen    (data_sram.wen),
        .offset (data_sram.addr[15:0]),
        .wdata  (data_sram.wdata),
        .switch (switch),
        .led    (led),
        .rdata  (conf_rdata)
    );

    // RAM contents are deliberately left out of reset
    always_ff @(posedge clk) begin
        if (data_sram.en && !conf_sel && data_sram.wen != 4'h0) begin
            mem[word_idx] <= byte_merge(mem[word_idx], data_sram.wdata, data_sram.wen);
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            data_sram.rdata <= 32'h0;
        end else if (data_sram.en) begin
            data_sram.rdata <= conf_sel ? conf_rdata : mem[word_idx];
        end
    end

endmodule

// File: tb/tb_data_sram_resp.sv
// tb/tb_data_sram_resp.sv - table-driven scoreboard bench for data_sram_resp
module tb_data_sram_resp;

    logic       clk = 1'b0;
    logic       resetn;
    logic [15:0] led;
    logic [7:0]  switch;

    data_sram_resp_if bus ();

    data_sram_resp dut (
        .clk       (clk),
        .resetn    (resetn),
        .data_sram (bus),
        .led       (led),
        .switch    (switch)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        en;
        logic [3:0]  wen;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        chk;
        logic [31:0] exp_rdata;
        logic [15:0] exp_led;
        string       name;
    } vec_t;

    typedef struct {
        logic        chk;
        logic [31:0] val;
        string       name;
    } sb_t;

    vec_t        vecs[$];
    sb_t         sb_q[$];
    int          tests = 0;
    int          fails = 0;
    logic [31:0] last_exp;
    logic        last_known;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Called at a negedge; consumes exactly one posedge and returns at the next negedge.
    task automatic step(input logic en, input logic [3:0] wen, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic chk, input logic [31:0] exp,
                        input string name);
        sb_t item;
        sb_t got;
        bus.en    = en;
        bus.wen   = wen;
        bus.addr  = addr;
        bus.wdata = wdata;
        if (en) begin
            item = '{chk, exp, name};
            last_known = chk;
            last_exp   = exp;
        end else begin
            item = '{last_known, last_exp, {name, "_hold"}};
        end
        sb_q.push_back(item);
        @(posedge clk);
        @(negedge clk);
        got = sb_q.pop_front();
        if (got.chk) check32(got.name, bus.rdata, got.val);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 32'h0, "idle");
    endtask

    initial begin
        resetn    = 1'b0;
        switch    = 8'h00;
        bus.en    = 1'b0;
        bus.wen   = 4'h0;
        bus.addr  = 32'h0;
        bus.wdata = 32'h0;
        last_exp   = 32'h0;
        last_known = 1'b1;

        vecs.push_back('{1, 4'hf, 32'h0000_0100, 32'h1234_5678, 0, 32'h0,         16'h0,    "ram_wr_full"});
        vecs.push_back('{1, 4'h5, 32'h0000_0100, 32'hAABB_CCDD, 1, 32'h1234_5678, 16'h0,    "ram_wr_lanes"});
        vecs.push_back('{1, 4'h0, 32'h0000_0100, 32'h0,         1, 32'h12BB_56DD, 16'h0,    "ram_rd_merge"});
        vecs.push_back('{1, 4'h0, 32'h0000_4100, 32'h0,         1, 32'h12BB_56DD, 16'h0,    "ram_rd_alias"});
        vecs.push_back('{1, 4'hf, 32'h0000_0200, 32'h0,         0, 32'h0,         16'h0,    "ram_clr_200"});
        vecs.push_back('{1, 4'hf, 32'h0000_0200, 32'hCAFE_F00D, 1, 32'h0,         16'h0,    "ram_rd_first"});
        vecs.push_back('{1, 4'h0, 32'h0000_0200, 32'h0,         1, 32'hCAFE_F00D, 16'h0,    "ram_b2b_rd"});
        vecs.push_back('{0, 4'h0, 32'h0,         32'h0,         1, 32'hCAFE_F00D, 16'h0,    "ram_hold1"});
        vecs.push_back('{0, 4'hf, 32'h0000_0200, 32'h5555_5555, 1, 32'hCAFE_F00D, 16'h0,    "ram_hold2"});
        vecs.push_back('{1, 4'h0, 32'h0000_0200, 32'h0,         1, 32'hCAFE_F00D, 16'h0,    "ram_no_wr_en0"});
        vecs.push_back('{1, 4'hf, 32'hbfaf_f000, 32'hFFFF_1234, 1, 32'h0,         16'h1234, "led_wr"});
        vecs.push_back('{1, 4'h0, 32'hbfaf_f000, 32'h0,         1, 32'h0000_1234, 16'h1234, "led_rd"});
        vecs.push_back('{1, 4'hf, 32'hbfaf_f0f0, 32'hFFFF_FFFF, 1, 32'h0,         16'h1234, "unmap_wr"});
        vecs.push_back('{1, 4'h0, 32'hbfaf_f0f0, 32'h0,         1, 32'h0,         16'h1234, "unmap_rd"});
        vecs.push_back('{1, 4'h0, 32'hbfaf_f000, 32'h0,         1, 32'h0000_1234, 16'h1234, "led_intact"});
        vecs.push_back('{1, 4'h2, 32'hbfaf_f000, 32'h0000_AB00, 1, 32'h0000_1234, 16'hAB34, "led_lane1"});
        vecs.push_back('{1, 4'h0, 32'hbfaf_f000, 32'h0,         1, 32'h0000_AB34, 16'hAB34, "led_rd2"});
        vecs.push_back('{1, 4'h3, 32'hbfaf_f020, 32'h5555_AAAA, 1, 32'h0,         16'hAB34, "scr_wr"});
        vecs.push_back('{1, 4'h0, 32'hbfaf_f020, 32'h0,         1, 32'h0000_AAAA, 16'hAB34, "scr_rd"});
        vecs.push_back('{1, 4'hf, 32'hbfaf_f010, 32'hFFFF_FFFF, 1, 32'h0000_00A5, 16'hAB34, "sw_wr_ro"});
        vecs.push_back('{1, 4'h0, 32'hbfaf_f010, 32'h0,         1, 32'h0000_00A5, 16'hAB34, "sw_rd2"});

        @(negedge clk);
        @(negedge clk);
        check32("reset_rdata", bus.rdata, 32'h0);
        check32("reset_led", {16'h0, led}, 32'h0);
        resetn = 1'b1;

        // Edge 0 is the first posedge after release
        idle(10);
        step(1, 4'h0, 32'hbfaf_e000, 32'h0, 1, 32'd10, "timer_e10");
        idle(9);
        step(1, 4'hf, 32'hbfaf_e000, 32'hFFFF_FFFE, 1, 32'd20, "timer_wr_e20");
        step(1, 4'h0, 32'hbfaf_e000, 32'h0, 1, 32'hFFFF_FFFE, "timer_e21");
        step(1, 4'h0, 32'hbfaf_e000, 32'h0, 1, 32'hFFFF_FFFF, "timer_e22");
        step(1, 4'h0, 32'hbfaf_e000, 32'h0, 1, 32'h0000_0000, "timer_wrap_e23");

        idle(6);
        switch = 8'hA5;
        idle(1);
        step(1, 4'h0, 32'hbfaf_f010, 32'h0, 1, 32'h0000_0000, "sw_e31");
        step(1, 4'h0, 32'hbfaf_f010, 32'h0, 1, 32'h0000_00A5, "sw_e32");

        foreach (vecs[i]) begin
            step(vecs[i].en, vecs[i].wen, vecs[i].addr, vecs[i].wdata,
                 vecs[i].chk, vecs[i].exp_rdata, vecs[i].name);
            check32({vecs[i].name, "_led"}, {16'h0, led}, {16'h0, vecs[i].exp_led});
        end

        bus.en    = 1'b1;
        bus.wen   = 4'hf;
        bus.addr  = 32'hbfaf_f020;
        bus.wdata = 32'hDEAD_BEEF;
        #2;
        resetn = 1'b0;
        #1;
        check32("rst_mid_rdata", bus.rdata, 32'h0);
        check32("rst_mid_led", {16'h0, led}, 32'h0);
        @(negedge clk);
        bus.en = 1'b0;
        @(negedge clk);
        resetn     = 1'b1;
        last_exp   = 32'h0;
        last_known = 1'b1;
        step(1, 4'h0, 32'hbfaf_e000, 32'h0, 1, 32'h0, "rst_timer");
        step(1, 4'h0, 32'hbfaf_f020, 32'h0, 1, 32'h0, "rst_scratch");
        step(1, 4'h0, 32'hbfaf_f000, 32'h0, 1, 32'h0, "rst_led_rd");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/data_sram_resp.md
# data_sram_resp

Responder for the CPU core's data-SRAM port. Services the `data_sram_*` en/wen/addr/wdata/rdata requests issued by the exe and mem stages with a fixed one-cycle read latency. Backs them with a word-addressed RAM array plus a small memory-mapped configuration register window (LED, switches, timer, scratch). Sits beside `mycpu_top` in the SoC top and replaces the vendor block RAM and confreg pair on the data side.

## Interface
- `ADDR_W`, 12: RAM word-index bits (4096 words, 16 KB).
- `CONF_HI`, 16'hbfaf: value of `addr[31:16]` that selects the config window.
- `clk` in 1: sole clock, rising edge.
- `resetn` in 1: reset, asynchronous and active-low.
- `data_sram_en` in 1: access request this cycle.
- `data_sram_wen` in 4: byte write enables; lane i writes `wdata[8i+7:8i]`; 0 means read.
- `data_sram_addr` in 32: byte address; `[1:0]` ignored.
- `data_sram_wdata` in 32: write data.
- `data_sram_rdata` out 32: read data, registered.
- `led` out 16: LED register.
- `switch` in 8: asynchronous board switches.

## Operation
- **Decode.** `conf_sel = (addr[31:16] == CONF_HI)`. Otherwise the access targets RAM at word `addr[ADDR_W+1:2]`. Upper bits alias and are not checked.
- **RAM.**
  - Read-first: on any `en` cycle, rdata captures the old word.
  - Then lanes with `wen[i]=1` update.
  - Contents are not reset.
- **Config registers** (offset = `addr[15:0]`). All writes are byte-lane masked.
  - 0xf000 LED: RW; bits [15:0] only; reads zero-extended.
  - 0xf010 SWITCH: RO; `{24'b0, switch_sync}`; writes ignored.
  - 0xe000 TIMER: RW, 32-bit, free-running +1 per cycle; wraps 0xffffffff→0.
  - 0xf020 SCRATCH: RW, 32-bit.
  - Any other offset: reads 0, writes ignored.
- **TIMER write.** The masked merge of wdata over the current value is loaded. A write beats the increment in the same cycle.
- **Conf reads.** Return the pre-update value of the access cycle (read-first, same as RAM).
- **Switch sync.** `switch` passes through a 2-flop synchronizer; `switch_sync` is the second flop.
- **`en`=0.** No state change except the timer increment and the synchronizer. `data_sram_rdata` holds its last value.
- **Reset values.**
  - `data_sram_rdata`=0, `led`=0, TIMER=0, SCRATCH=0, sync flops=0.
  - Reset asserted mid-access aborts it: no write lands in config registers. The RAM write for that edge is don't-care.

## Timing
- **Read latency.** Request at edge n (en=1, wen=0) → `data_sram_rdata` valid after edge n, i.e. through cycle n+1. This matches the mem stage sampling one cycle after exe issue.
- **Throughput.** One access per cycle; no backpressure, no stall output.
- **Back-to-back.** A write at n then a read of the same word at n+1 returns the new data.
- **LED.** Write at edge n → `led` updates after edge n.
- **TIMER.** Write of V at edge n:
  - TIMER=V during cycle n+1.
  - A read issued at edge n+k (k≥1) returns V+k−1.
- **Switch.** A change stable before edge n is visible in `switch_sync` after edge n+1. The earliest read issued at n+2 returns it.

## Structure
- **Package `dsram_pkg`:**
  - `CONF_HI` default.
  - Offsets `OFF_LED`, `OFF_SWITCH`, `OFF_TIMER`, `OFF_SCRATCH`.
  - A `byte_merge(old, new, wen)` function.
- **Sub-module `conf_regs`:** LED, TIMER, SCRATCH, switch synchronizer, and the read mux. Returns a 32-bit combinational read value.
- **Top:** holds the RAM array, decode, and the final registered `rdata` mux.

## Test plan
- **RAM full word and byte lanes.** Write 0x12345678 to 0x00000100 with wen=4'hf. Then write 0xAABBCCDD with wen=4'b0101 → the read at 0x100 returns 0x12BB56DD, valid exactly one cycle after en.
- **Read-first and hold.** Write 0xCAFEF00D to 0x200 while the word holds 0x0 → rdata=0x0 that cycle. Read next cycle → 0xCAFEF00D. Deassert en → rdata stays 0xCAFEF00D.
- **LED and unmapped offset.** Write 0xFFFF1234 to 0xbfaff000 → `led`=0x1234 and readback 0x00001234. Write to 0xbfaff0f0, then read it → 0, with no other register changed.
- **Timer.** After reset, read 0xbfafe000 at edge 10 → 10. Write 0xFFFFFFFE at edge 20 → reads at edges 21, 22, 23 return 0xFFFFFFFE, 0xFFFFFFFF, 0x0.
- **Switch sync.** Change `switch` 0x00→0xA5 before edge 30. A read of 0xbfaff010 at edge 31 → 0x00; a read at edge 32 → 0xA5.
- **Reset mid-operation.** Assert resetn=0 asynchronously between edges while a SCRATCH write (0xDEADBEEF) is presented → `rdata`, `led`, TIMER and SCRATCH are 0 immediately. After release, SCRATCH reads 0.
